pll_phase_stepper: RTL
======================

PLL_PHASE_STEPPER -- requirements
Module: pll_phase_stepper

Interface
REQ-001 Parameter: STEP_TIMEOUT, default 255, max clk cycles waited on each phasedone edge before abort.
REQ-002 Parameter: CLKSWITCH_CYCLES, default 4, clkswitch pulse width in clk cycles.
REQ-003 clk  in  1  system clock; all logic on posedge clk.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 updatepll  in  1  single-cycle request to apply pll_shifts / pll_clk_src.
REQ-006 pll_clk_src  in  1  requested PLL input clock (0 = inclk0, 1 = inclk1).
REQ-007 pll_shifts[0:5]  in  6x8  target absolute phase position per counter; entry k maps to phasecounterselect k+1 (M, C0..C4).
REQ-008 phasedone  in  1  altpll phasedone (low while a step is in progress).
REQ-009 phasecounterselect  out  3  altpll counter select.
REQ-010 phaseupdown  out  1  1 = step up, 0 = step down.
REQ-011 phasestep  out  1  altpll phase step strobe.
REQ-012 clkswitch  out  1  altpll clock switch strobe.
REQ-013 busy  out  1  high from request accept until completion.
REQ-014 done  out  1  one-cycle pulse on completion (normal or aborted).
REQ-015 timeout_err  out  1  sticky abort flag; cleared when the next request is accepted.

Function
REQ-016 States: IDLE, LATCH, SWITCH, SELECT, STEP, WAIT_LO, WAIT_HI, NEXT, FINISH.
REQ-017 IDLE: updatepll=1 -> LATCH next cycle, busy=1, timeout_err=0.
REQ-018 LATCH: copy pll_shifts and pll_clk_src into internal target registers; later input changes are ignored until the next accept; counter index k=0.
REQ-019 Internal cur[0:5] (8 bit) holds the believed position of each counter; cur_src holds the believed clock source.
REQ-020 After LATCH: if target source differs from cur_src -> SWITCH, otherwise -> SELECT.
REQ-021 SWITCH: clkswitch=1 for exactly CLKSWITCH_CYCLES cycles; cur_src updated; then -> SELECT.
REQ-022 delta = target[k] - cur[k], taken mod 256 (8-bit wrap); delta=0 -> NEXT; delta[7]=0 -> step up, delta times; delta[7]=1 -> step down, 256-delta times (shortest path; 128 steps down).
REQ-023 SELECT: drive phasecounterselect=k+1 and phaseupdown; hold both for 1 cycle, then -> STEP; both stay stable through WAIT_HI.
REQ-024 STEP: phasestep=1 for exactly 2 cycles, then -> WAIT_LO.
REQ-025 WAIT_LO: wait for phasedone=0; WAIT_HI: wait for phasedone=1; each wait has its own timeout counter.
REQ-026 On phasedone=1 in WAIT_HI: cur[k] += 1 or -= 1 (mod 256); if cur[k] != target[k] -> SELECT, otherwise -> NEXT.
REQ-027 Timeout: either wait exceeding STEP_TIMEOUT cycles -> timeout_err=1, phasestep=0, -> FINISH; cur[k] is not updated.
REQ-028 NEXT: k<5 -> k+1, -> SELECT; k=5 -> FINISH.
REQ-029 FINISH: done=1 for one cycle, busy=0, -> IDLE.
REQ-030 updatepll while busy: latched as one pending request (extra requests merge); it is accepted from IDLE on the cycle after FINISH, sampling inputs at that time.
REQ-031 phasecounterselect=0, phaseupdown=0, and phasestep=0 whenever the state is not SELECT, STEP, WAIT_LO, or WAIT_HI.

Reset
REQ-032 reset_n=0 asynchronously sets the state to IDLE and clears the pending flag, cur[], cur_src, targets, and k.
REQ-033 Reset values: phasecounterselect=0, phaseupdown=0, phasestep=0, clkswitch=0, busy=0, done=0, timeout_err=0.
REQ-034 Reset mid-operation aborts immediately with no done pulse; the positions-to-zero reset matches the PLL being reset alongside.

Configuration
REQ-035 With macro PLL_CLKSWITCH_EN defined, REQ-020/021 apply.
REQ-036 With PLL_CLKSWITCH_EN undefined: the SWITCH state and cur_src are omitted, pll_clk_src is ignored, and clkswitch is tied 0.

Verification
REQ-037 Set pll_shifts={0,3,0,0,0,0} and pulse updatepll, with a phasedone model (low 2 cycles after phasestep, high 5 cycles later) -> 3 up-steps with select=2, then done pulse; cur[1]=3.
REQ-038 From cur[1]=3, set target 1 -> 2 down-steps with phaseupdown=0; set target 250 from 0 -> 6 down-steps (wrap).
REQ-039 With PLL_CLKSWITCH_EN, pll_clk_src=1 and all shifts 0 -> clkswitch high 4 cycles, no phasestep, done.
REQ-040 Tie phasedone=1 -> after first STEP, timeout after 255 cycles, timeout_err=1, done pulse, cleared on next updatepll.
REQ-041 updatepll twice during a running update -> exactly one further run after FINISH; reset_n low mid-WAIT_HI -> all outputs 0, busy 0, no done.

Source files
------------

// File: rtl/pll_phase_stepper.sv
// Steps altpll dynamic phase counters to latched absolute targets by the shortest path.
// Optional input-clock switching is built when macro PLL_CLKSWITCH_EN is defined.
module pll_phase_stepper #(
    parameter int STEP_TIMEOUT     = 255,
    parameter int CLKSWITCH_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       updatepll,
    input  logic       pll_clk_src,
    input  logic [7:0] pll_shifts [0:5],
    input  logic       phasedone,
    output logic [2:0] phasecounterselect,
    output logic       phaseupdown,
    output logic       phasestep,
    output logic       clkswitch,
    output logic       busy,
    output logic       done,
    output logic       timeout_err
);

    localparam int TW = $clog2(STEP_TIMEOUT + 1) + 1;

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_LATCH   = 4'd1;
    localparam logic [3:0] S_SWITCH  = 4'd2;
    localparam logic [3:0] S_SELECT  = 4'd3;
    localparam logic [3:0] S_STEP    = 4'd4;
    localparam logic [3:0] S_WAIT_LO = 4'd5;
    localparam logic [3:0] S_WAIT_HI = 4'd6;
    localparam logic [3:0] S_NEXT    = 4'd7;
    localparam logic [3:0] S_FINISH  = 4'd8;

    logic [3:0]    state_r, state_n;
    logic [2:0]    k_r, k_n;
    logic          up_r, up_n;
    logic [15:0]   cnt_r, cnt_n;
    logic [TW-1:0] to_r, to_n;
    logic          pend_r, pend_n;
    logic          toerr_n;
    logic [7:0]    tgt_r [0:5];
    logic [7:0]    tgt_n [0:5];
    logic [7:0]    cur_r [0:5];
    logic [7:0]    cur_n [0:5];
    logic [7:0]    delta_s;
    logic          active_s;

`ifdef PLL_CLKSWITCH_EN
    logic          cur_src_r, cur_src_n;
    logic          tgt_src_r, tgt_src_n;
`else
    logic          unused_src_s;
    assign unused_src_s = pll_clk_src;
    assign clkswitch    = 1'b0;
`endif

    // Next-state and datapath update for the stepping sequencer
    always_comb begin
        state_n = state_r;
        k_n     = k_r;
        up_n    = up_r;
        cnt_n   = cnt_r;
        to_n    = to_r;
        toerr_n = timeout_err;
        tgt_n   = tgt_r;
        cur_n   = cur_r;
        delta_s = 8'd0;
`ifdef PLL_CLKSWITCH_EN
        cur_src_n = cur_src_r;
        tgt_src_n = tgt_src_r;
`endif
        if (updatepll && (state_r != S_IDLE)) begin
            pend_n = 1'b1;
        end else begin
            pend_n = pend_r;
        end

        case (state_r)
            S_IDLE: begin
                if (updatepll || pend_r) begin
                    state_n = S_LATCH;
                    pend_n  = 1'b0;
                    toerr_n = 1'b0;
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_LATCH: begin
                tgt_n = pll_shifts;
                k_n   = 3'd0;
`ifdef PLL_CLKSWITCH_EN
                tgt_src_n = pll_clk_src;
                if (pll_clk_src != cur_src_r) begin
                    state_n = S_SWITCH;
                    cnt_n   = 16'd0;
                end else begin
                    state_n = S_SELECT;
                end
`else
                state_n = S_SELECT;
`endif
            end
            S_SWITCH: begin
                if (cnt_r == 16'(CLKSWITCH_CYCLES - 1)) begin
`ifdef PLL_CLKSWITCH_EN
                    cur_src_n = tgt_src_r;
`endif
                    state_n = S_SELECT;
                end else begin
                    cnt_n = cnt_r + 16'd1;
                end
            end
            S_SELECT: begin
                state_n = S_STEP;
                cnt_n   = 16'd0;
            end
            S_STEP: begin
                if (cnt_r == 16'd1) begin
                    state_n = S_WAIT_LO;
                    to_n    = {TW{1'b0}};
                end else begin
                    cnt_n = cnt_r + 16'd1;
                end
            end
            S_WAIT_LO: begin
                if (!phasedone) begin
                    state_n = S_WAIT_HI;
                    to_n    = {TW{1'b0}};
                end else if (to_r == TW'(STEP_TIMEOUT)) begin
                    toerr_n = 1'b1;
                    state_n = S_FINISH;
                end else begin
                    to_n = to_r + {{(TW-1){1'b0}}, 1'b1};
                end
            end
            S_WAIT_HI: begin
                // Reaching the target is detected by the zero-delta check on re-entry to SELECT
                if (phasedone) begin
                    cur_n[k_r] = up_r ? (cur_r[k_r] + 8'd1) : (cur_r[k_r] - 8'd1);
                    state_n    = S_SELECT;
                end else if (to_r == TW'(STEP_TIMEOUT)) begin
                    toerr_n = 1'b1;
                    state_n = S_FINISH;
                end else begin
                    to_n = to_r + {{(TW-1){1'b0}}, 1'b1};
                end
            end
            S_NEXT: begin
                if (k_r == 3'd5) begin
                    state_n = S_FINISH;
                end else begin
                    k_n     = k_r + 3'd1;
                    state_n = S_SELECT;
                end
            end
            S_FINISH: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        if ((state_n == S_SELECT) && (state_r != S_SELECT)) begin
            delta_s = tgt_n[k_n] - cur_n[k_n];
            if (delta_s == 8'd0) begin
                state_n = S_NEXT;
            end else begin
                up_n = ~delta_s[7];
            end
        end else begin
            delta_s = 8'd0;
        end
    end

    assign active_s = (state_n == S_SELECT) || (state_n == S_STEP) ||
                      (state_n == S_WAIT_LO) || (state_n == S_WAIT_HI);

    // State, position bookkeeping and registered PLL control outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r            <= S_IDLE;
            k_r                <= 3'd0;
            up_r               <= 1'b0;
            cnt_r              <= 16'd0;
            to_r               <= {TW{1'b0}};
            pend_r             <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                tgt_r[i] <= 8'd0;
                cur_r[i] <= 8'd0;
            end
            phasecounterselect <= 3'd0;
            phaseupdown        <= 1'b0;
            phasestep          <= 1'b0;
            busy               <= 1'b0;
            done               <= 1'b0;
            timeout_err        <= 1'b0;
        end else begin
            state_r            <= state_n;
            k_r                <= k_n;
            up_r               <= up_n;
            cnt_r              <= cnt_n;
            to_r               <= to_n;
            pend_r             <= pend_n;
            tgt_r              <= tgt_n;
            cur_r              <= cur_n;
            phasecounterselect <= active_s ? (k_n + 3'd1) : 3'd0;
            phaseupdown        <= active_s ? up_n : 1'b0;
            phasestep          <= (state_n == S_STEP);
            busy               <= (state_n != S_IDLE) && (state_n != S_FINISH);
            done               <= (state_n == S_FINISH);
            timeout_err        <= toerr_n;
        end
    end

`ifdef PLL_CLKSWITCH_EN
    // Clock-source tracking and the switch strobe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_src_r <= 1'b0;
            tgt_src_r <= 1'b0;
            clkswitch <= 1'b0;
        end else begin
            cur_src_r <= cur_src_n;
            tgt_src_r <= tgt_src_n;
            clkswitch <= (state_n == S_SWITCH);
        end
    end
`endif

endmodule
